// File: rtl/gpu_pkg.sv
// Shared GPU definitions: host bus cycle types, default instruction geometry and
// the opcode field location decoded by the command queue, pixel and signal generators.
package gpu_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_INSTR_BYTES = 4;

  // Classification of one host bus cycle at the rising edge.
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_ABORT = 2'd2
  } bus_cycle_e;

  // LSB of the opcode field: the opcode is the first byte sent, i.e. the top byte.
  function automatic int unsigned opcode_lsb(input int unsigned data_w,
                                             input int unsigned instr_bytes);
    return (instr_bytes - 1) * data_w;
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_wdata write side;
//        i_pop read side; o_rdata always shows the head entry; o_level occupancy;
//        o_full asserted when o_level == DEPTH.
// Push while full and pop while empty are ignored.
module gpu_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & (level_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_level = level_q;

endmodule

// File: rtl/gpu_cmd_queue.sv
// GPU command queue: assembles host bus bytes MSB-first into instructions and
// buffers them for the pixel/signal generators.
// Ports: i_clk/i_rst_n clock and async active-low reset;
//        i_we/i_en/i_data host bus, o_ack registered accept pulse, o_busy FIFO full;
//        i_vblank release gate; o_instruction/o_instruction_valid/i_instruction_accept
//        consumer handshake; o_level occupancy; o_overflow sticky dropped-write flag.
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int unsigned DEPTH       = 4,
  parameter bit          VBLANK_GATE = 1'b1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_we,
  input  logic                            i_en,
  input  logic [DATA_W-1:0]               i_data,
  output logic                            o_ack,
  output logic                            o_busy,
  input  logic                            i_vblank,
  output logic [DATA_W*INSTR_BYTES-1:0]   o_instruction,
  output logic                            o_instruction_valid,
  input  logic                            i_instruction_accept,
  output logic [$clog2(DEPTH+1)-1:0]      o_level,
  output logic                            o_overflow
);

  localparam int unsigned INSTR_W = DATA_W * INSTR_BYTES;
  localparam int unsigned CNT_W   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  bus_cycle_e         cyc_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic               ack_q, ack_d;
  logic               ovf_q, ovf_d;
  logic [INSTR_W-1:0] word_c;
  logic               last_byte_c;
  logic               push_c;
  logic               pop_c;

  // Bus cycle classification.
  always_comb begin
    cyc_c = BUS_IDLE;
    if (i_en) cyc_c = i_we ? BUS_WRITE : BUS_ABORT;
  end

  assign last_byte_c = (cnt_q == CNT_W'(INSTR_BYTES - 1));

  // Current byte dropped into its slot: byte n of the instruction goes to slot INSTR_BYTES-1-n.
  always_comb begin
    word_c = asm_q;
    for (int b = 0; b < int'(INSTR_BYTES); b++) begin
      if (cnt_q == CNT_W'(int'(INSTR_BYTES) - 1 - b)) word_c[b*DATA_W +: DATA_W] = i_data;
    end
  end

  // Assembly, ack and overflow next-state.
  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    ack_d  = 1'b0;
    ovf_d  = ovf_q;
    push_c = 1'b0;
    case (cyc_c)
      BUS_WRITE: begin
        if (o_busy) begin
          ovf_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (last_byte_c) begin
            push_c = 1'b1;
            cnt_d  = '0;
            asm_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            asm_d = word_c;
          end
        end
      end
      BUS_ABORT: begin
        cnt_d = '0;
        asm_d = '0;
        ovf_d = 1'b0;
        ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
    end
  end

  // Head is releasable only when occupied and, if gated, during vertical blanking.
  assign o_instruction_valid = (o_level != '0) && (!VBLANK_GATE || i_vblank);
  assign pop_c               = o_instruction_valid & i_instruction_accept;

  gpu_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_c),
    .i_wdata (word_c),
    .i_pop   (pop_c),
    .o_rdata (o_instruction),
    .o_level (o_level),
    .o_full  (o_busy)
  );

  assign o_ack      = ack_q;
  assign o_overflow = ovf_q;

endmodule
